// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// The AR register is kept as one packed struct so that loading and holding it stays a single assignment.
package axi_rd_pkg;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [3:0] I_ID_DEFAULT    = 4'd0;
  localparam logic [3:0] D_ID_DEFAULT    = 4'd1;
  localparam logic [3:0] I_CACHE_DEFAULT = 4'hf;
  localparam logic [3:0] D_CACHE_DEFAULT = 4'h0;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Requester index used by the arbiter: bit 0 is the I side, bit 1 is the D side.
  localparam int SIDE_I = 0;
  localparam int SIDE_D = 1;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  cache;
  } ar_fields_t;

  localparam ar_fields_t AR_FIELDS_ZERO = '0;

endpackage

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
// On a tie it grants the side that did not win last; a lone requester always wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 0: index 0 (I side) won last, 1: index 1 (D side) won last.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI AR/R channel pair between the I-cache refill side and the D-side uncached reads.
// AR is fully registered; R beats are steered back to their requester by rid.
module axi_read_arbiter
  import axi_rd_pkg::*;
#(
  parameter logic [3:0] I_ID    = I_ID_DEFAULT,
  parameter logic [3:0] D_ID    = D_ID_DEFAULT,
  parameter logic [3:0] I_CACHE = I_CACHE_DEFAULT,
  parameter logic [3:0] D_CACHE = D_CACHE_DEFAULT
) (
  input  logic        clk,
  input  logic        areset,

  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_len,

  output logic        i_rvalid,
  input  logic        i_rready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_size,

  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [31:0] d_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic        rd_err
);

  ar_state_t  ar_state_q, ar_state_d;
  ar_fields_t ar_q, ar_d;
  logic       i_busy_q, i_busy_d;
  logic       d_busy_q, d_busy_d;
  logic       rd_err_q, rd_err_d;

  logic       ar_idle;
  logic [1:0] arb_req;
  logic [1:0] arb_grant;
  logic       i_accept;
  logic       d_accept;
  logic       ar_hs;

  logic       route_i;
  logic       route_d;
  logic       r_ready;
  logic       r_hs;

  // ---------------------------------------------------------------- request side
  assign ar_idle = (ar_state_q == AR_IDLE);

  always_comb begin
    arb_req         = '0;
    arb_req[SIDE_I] = ar_idle & i_req_valid & ~i_busy_q;
    arb_req[SIDE_D] = ar_idle & d_req_valid & ~d_busy_q;
  end

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .areset (areset),
    .req    (arb_req),
    .update (i_accept | d_accept),
    .grant  (arb_grant)
  );

  assign i_req_ready = ar_idle & ~i_busy_q & arb_grant[SIDE_I];
  assign d_req_ready = ar_idle & ~d_busy_q & arb_grant[SIDE_D];
  assign i_accept    = i_req_valid & i_req_ready;
  assign d_accept    = d_req_valid & d_req_ready;

  // ---------------------------------------------------------------- AR register
  assign ar_hs = (ar_state_q == AR_SEND) & arready;

  always_comb begin
    ar_state_d = ar_state_q;
    ar_d       = ar_q;
    case (ar_state_q)
      AR_IDLE: begin
        if (i_accept) begin
          ar_d.id    = I_ID;
          ar_d.addr  = i_req_addr;
          ar_d.len   = i_req_len;
          ar_d.size  = SIZE_WORD;
          ar_d.burst = BURST_INCR;
          ar_d.cache = I_CACHE;
          ar_state_d = AR_SEND;
        end else if (d_accept) begin
          ar_d.id    = D_ID;
          ar_d.addr  = d_req_addr;
          ar_d.len   = 4'd0;
          ar_d.size  = d_req_size;
          ar_d.burst = BURST_INCR;
          ar_d.cache = D_CACHE;
          ar_state_d = AR_SEND;
        end
      end
      AR_SEND: begin
        if (arready) begin
          ar_state_d = AR_IDLE;
        end
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;
  assign arburst = ar_q.burst;
  assign arcache = ar_q.cache;
  assign arlock  = 2'b00;
  assign arprot  = 3'b000;
  assign arvalid = (ar_state_q == AR_SEND);

  // ---------------------------------------------------------------- R routing
  always_comb begin
    route_i  = 1'b0;
    route_d  = 1'b0;
    r_ready  = 1'b1;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if ((rid == I_ID) && i_busy_q) begin
      route_i  = 1'b1;
      r_ready  = i_rready;
      i_rvalid = rvalid;
    end else if ((rid == D_ID) && d_busy_q) begin
      route_d  = 1'b1;
      r_ready  = d_rready;
      d_rvalid = rvalid;
    end
  end

  assign rready  = r_ready;
  assign r_hs    = rvalid & r_ready;
  assign i_rdata = rdata;
  assign d_rdata = rdata;
  assign i_rlast = rlast;

  // ---------------------------------------------------------------- outstanding flags and error
  always_comb begin
    i_busy_d = i_busy_q;
    d_busy_d = d_busy_q;
    if (r_hs && rlast && route_i) i_busy_d = 1'b0;
    if (r_hs && rlast && route_d) d_busy_d = 1'b0;
    // A side is never retiring while its own AR is still pending, so setting last is safe.
    if (ar_hs && (ar_q.id == I_ID)) i_busy_d = 1'b1;
    if (ar_hs && (ar_q.id == D_ID)) d_busy_d = 1'b1;
  end

  always_comb begin
    rd_err_d = rd_err_q;
    if (rvalid && !route_i && !route_d) rd_err_d = 1'b1;
    if (r_hs && (rresp != RESP_OKAY))    rd_err_d = 1'b1;
  end

  assign rd_err = rd_err_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ar_state_q <= AR_IDLE;
      ar_q       <= AR_FIELDS_ZERO;
      i_busy_q   <= 1'b0;
      d_busy_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_q       <= ar_d;
      i_busy_q   <= i_busy_d;
      d_busy_q   <= d_busy_d;
      rd_err_q   <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: reset, I burst, errors, tie-break, interleaving, reset mid-burst.
// Inputs change 1 time unit after the rising edge; checks happen 1 unit later, well before the next edge.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        areset;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic [3:0]  i_req_len;
  logic        i_rvalid, i_rready, i_rlast;
  logic [31:0] i_rdata;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic [2:0]  d_req_size;
  logic        d_rvalid, d_rready;
  logic [31:0] d_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        rd_err;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk (clk), .areset (areset),
    .i_req_valid (i_req_valid), .i_req_ready (i_req_ready),
    .i_req_addr (i_req_addr), .i_req_len (i_req_len),
    .i_rvalid (i_rvalid), .i_rready (i_rready), .i_rdata (i_rdata), .i_rlast (i_rlast),
    .d_req_valid (d_req_valid), .d_req_ready (d_req_ready),
    .d_req_addr (d_req_addr), .d_req_size (d_req_size),
    .d_rvalid (d_rvalid), .d_rready (d_rready), .d_rdata (d_rdata),
    .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
    .arburst (arburst), .arlock (arlock), .arcache (arcache), .arprot (arprot),
    .arvalid (arvalid), .arready (arready),
    .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid),
    .rready (rready), .rd_err (rd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ar(input string tag, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] len, input logic [2:0] size, input logic [3:0] cache);
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd1);
    chk({tag, "_arid"},    {28'd0, arid}, {28'd0, id});
    chk({tag, "_araddr"},  araddr, addr);
    chk({tag, "_arlen"},   {28'd0, arlen}, {28'd0, len});
    chk({tag, "_arsize"},  {29'd0, arsize}, {29'd0, size});
    chk({tag, "_arburst"}, {30'd0, arburst}, 32'd1);
    chk({tag, "_arcache"}, {28'd0, arcache}, {28'd0, cache});
    chk({tag, "_arlockprot"}, {27'd0, arlock, arprot}, 32'd0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #3;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    i_req_valid = 0; i_req_addr = 0; i_req_len = 0; i_rready = 1;
    d_req_valid = 0; d_req_addr = 0; d_req_size = 0; d_rready = 1;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;

    // ---- reset state (a stray beat during reset must not reach i_rvalid)
    #2;
    rvalid = 1; rid = 4'd0;
    settle();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arfields", {16'd0, arid, arlen, arcache, arsize, 1'b0}, 32'd0);
    chk("rst_rd_err", {31'd0, rd_err}, 32'd0);
    chk("rst_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    rvalid = 0;
    tick();
    areset = 1'b0;

    // ---- single I burst, arready 2 cycles late
    i_req_valid = 1; i_req_addr = 32'h1fc0_0000; i_req_len = 4'd3;
    settle();
    chk("i1_req_ready", {31'd0, i_req_ready}, 32'd1);
    chk("i1_no_comb_arvalid", {31'd0, arvalid}, 32'd0);
    tick();
    i_req_valid = 0; i_req_addr = 32'h0;
    settle();
    chk_ar("i1_c1", 4'd0, 32'h1fc0_0000, 4'd3, 3'b010, 4'hf);
    chk("i1_busy_not_ready", {31'd0, i_req_ready}, 32'd0);
    tick();
    chk_ar("i1_c2", 4'd0, 32'h1fc0_0000, 4'd3, 3'b010, 4'hf);
    tick();
    arready = 1;
    settle();
    chk_ar("i1_c3", 4'd0, 32'h1fc0_0000, 4'd3, 3'b010, 4'hf);
    tick();
    arready = 0;
    settle();
    chk("i1_ar_done", {31'd0, arvalid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1; rid = 4'd0; rdata = 32'ha000_0000 + k; rlast = (k == 3);
      if (k == 1) begin
        i_rready = 0;
        settle();
        chk("i1_bp_rready", {31'd0, rready}, 32'd0);
        chk("i1_bp_rvalid", {31'd0, i_rvalid}, 32'd1);
        if (rvalid && rready) beats++;
        tick();
        i_rready = 1;
      end
      if (k == 3) i_req_valid = 1;
      settle();
      chk($sformatf("i1_beat%0d_rvalid", k), {30'd0, i_rvalid, d_rvalid}, 32'd2);
      chk($sformatf("i1_beat%0d_rdata", k), i_rdata, 32'ha000_0000 + k);
      chk($sformatf("i1_beat%0d_rlast", k), {31'd0, i_rlast}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("i1_retire_same_cycle_ready", {31'd0, i_req_ready}, 32'd0);
      if (rvalid && rready) beats++;
      tick();
    end
    rvalid = 0; rlast = 0;
    settle();
    chk("i1_beat_count", beats, 32'd4);
    chk("i1_busy_cleared_ready", {31'd0, i_req_ready}, 32'd1);
    chk("i1_rd_err", {31'd0, rd_err}, 32'd0);
    i_req_valid = 0;

    // ---- unexpected rid: dropped with rready=1, rd_err sticky
    tick();
    i_rready = 0; d_rready = 0;
    rvalid = 1; rid = 4'd5; rdata = 32'h5555_5555; rlast = 1;
    settle();
    chk("rid5_rready", {31'd0, rready}, 32'd1);
    chk("rid5_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rid5_err_before", {31'd0, rd_err}, 32'd0);
    tick();
    rvalid = 0; rlast = 0; i_rready = 1; d_rready = 1;
    settle();
    chk("rid5_err_set", {31'd0, rd_err}, 32'd1);
    tick();
    chk("rid5_err_sticky", {31'd0, rd_err}, 32'd1);

    // ---- tie after reset: D first
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h1fc0_0100; i_req_len = 4'd1;
    d_req_valid = 1; d_req_addr = 32'hbfd0_0010; d_req_size = 3'b010;
    settle();
    chk("tie1_grants", {30'd0, i_req_ready, d_req_ready}, 32'd1);
    tick();
    d_req_valid = 0;
    settle();
    chk_ar("tie1_d", 4'd1, 32'hbfd0_0010, 4'd0, 3'b010, 4'h0);
    chk("tie1_i_waits", {31'd0, i_req_ready}, 32'd0);
    arready = 1;
    tick();
    arready = 0;
    settle();
    chk("tie1_i_ready_after_hs", {31'd0, i_req_ready}, 32'd1);
    tick();
    i_req_valid = 0;
    settle();
    chk_ar("tie1_i", 4'd0, 32'h1fc0_0100, 4'd1, 3'b010, 4'hf);
    arready = 1;
    tick();
    arready = 0;

    // ---- interleaved returns
    rvalid = 1; rid = 4'd0; rdata = 32'h1111_1111; rlast = 0;
    settle();
    chk("il_i0_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    chk("il_i0_rdata", i_rdata, 32'h1111_1111);
    tick();
    rid = 4'd1; rdata = 32'hcafe_0001; rlast = 1;
    settle();
    chk("il_d_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd1);
    chk("il_d_rdata", d_rdata, 32'hcafe_0001);
    tick();
    rid = 4'd0; rdata = 32'h2222_2222; rlast = 1;
    settle();
    chk("il_i1_rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    chk("il_i1_rlast", {31'd0, i_rlast}, 32'd1);
    tick();
    rvalid = 0; rlast = 0;
    settle();
    chk("il_rd_err", {31'd0, rd_err}, 32'd0);

    // ---- second tie: I won last, so D wins
    i_req_valid = 1; d_req_valid = 1; d_req_addr = 32'hbfd0_0014; d_req_size = 3'b000;
    settle();
    chk("tie2_grants", {30'd0, i_req_ready, d_req_ready}, 32'd1);
    tick();
    i_req_valid = 0; d_req_valid = 0;
    settle();
    chk_ar("tie2_d", 4'd1, 32'hbfd0_0014, 4'd0, 3'b000, 4'h0);
    arready = 1;
    tick();
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'hdead_beef; rresp = 2'b10; rlast = 1;
    settle();
    chk("slverr_d_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd1);
    chk("slverr_d_rdata", d_rdata, 32'hdead_beef);
    tick();
    rvalid = 0; rresp = 2'b00; rlast = 0;
    settle();
    chk("slverr_rd_err", {31'd0, rd_err}, 32'd1);
    // D won last, so the next tie goes to I
    i_req_valid = 1; d_req_valid = 1;
    settle();
    chk("tie3_grants", {30'd0, i_req_ready, d_req_ready}, 32'd2);
    i_req_valid = 0; d_req_valid = 0;

    // ---- reset mid-burst with a D AR pending
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h1fc0_0200; i_req_len = 4'd3;
    tick();
    i_req_valid = 0; arready = 1;
    tick();
    arready = 0;
    d_req_valid = 1; d_req_addr = 32'hbfd0_0020; d_req_size = 3'b000;
    rvalid = 1; rid = 4'd0; rdata = 32'hb000_0000; rlast = 0;
    settle();
    chk("rm_d_ready", {31'd0, d_req_ready}, 32'd1);
    chk("rm_beat0", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    tick();
    d_req_valid = 0; rdata = 32'hb000_0001;
    settle();
    chk_ar("rm_d_pending", 4'd1, 32'hbfd0_0020, 4'd0, 3'b000, 4'h0);
    chk("rm_beat1_with_ar", {31'd0, i_rvalid}, 32'd1);
    tick();
    rdata = 32'hb000_0002;
    settle();
    areset = 1'b1;
    #1;
    chk("rm_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rm_araddr", araddr, 32'd0);
    chk("rm_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("rm_rready", {31'd0, rready}, 32'd1);
    chk("rm_rd_err", {31'd0, rd_err}, 32'd0);
    tick();
    areset = 1'b0;
    d_req_valid = 1; d_req_addr = 32'hbfd0_0030; d_req_size = 3'b001;
    settle();
    chk("rm_release_d_ready", {31'd0, d_req_ready}, 32'd1);
    tick();
    d_req_valid = 0; rvalid = 0;
    settle();
    chk_ar("rm_release_d", 4'd1, 32'hbfd0_0030, 4'd0, 3'b001, 4'h0);
    chk("rm_late_beat_err", {31'd0, rd_err}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
